// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath and the hazard unit: decoded register fields and
// control bits in, pipeline stall/flush and forwarding selects out.
interface hazard_ctrl_if;
    logic [4:0] rs1D, rs2D;
    logic [4:0] rs1E, rs2E;
    logic [4:0] rdE, rdM, rdW;
    logic       memReadE;
    logic       regWriteM, regWriteW;
    logic       pcSrcE;
    logic       mulDivE;
    logic       memReqM, memReadyM;

    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM;
    logic [1:0] forwardAE, forwardBE;
    logic       mdBusy;
    logic       memErr;

    // Datapath side.
    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
               memReadE, regWriteM, regWriteW, pcSrcE, mulDivE, memReqM, memReadyM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushM,
               forwardAE, forwardBE, mdBusy, memErr
    );

    // Hazard unit side.
    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
               memReadE, regWriteM, regWriteW, pcSrcE, mulDivE, memReqM, memReadyM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushM,
               forwardAE, forwardBE, mdBusy, memErr
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX forwarding selects, load-use / branch / mul-div / dmem-wait
// stall and flush controls, plus a sticky watchdog on long data-memory waits.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY  = 4,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned    WAIT_W   = $clog2(MEM_TIMEOUT);
    localparam logic [3:0]     MD_INIT  = 4'((MD_LATENCY >= 2) ? MD_LATENCY - 2 : 0);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    md_state_e         state_q, state_d;
    logic [3:0]        md_cnt_q, md_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic       mem_stall, lw_stall, md_stall;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m;
    logic [1:0] fwd_a, fwd_b;

    // MEM-stage result is younger than WB, so it takes precedence.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.regWriteM && hz.rdM != 5'd0 && hz.rdM == rs)
            return 2'b10;
        else if (hz.regWriteW && hz.rdW != 5'd0 && hz.rdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mem_stall = hz.memReqM & ~hz.memReadyM;
    assign lw_stall  = hz.memReadE & (hz.rdE != 5'd0) &
                       ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));
    assign fwd_a     = fwd_sel(hz.rs1E);
    assign fwd_b     = fwd_sel(hz.rs2E);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hz.mulDivE && (MD_LATENCY > 1)) begin
                    md_stall = 1'b1;
                    if (!mem_stall) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = MD_INIT;
                    end
                end
            end
            MD_BUSY: begin
                if (md_cnt_q != 4'd0) begin
                    md_stall = 1'b1;
                    if (!mem_stall) md_cnt_d = md_cnt_q - 4'd1;
                end else if (!mem_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter saturates at the threshold; the error flag is sticky until reset.
    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_MAX) mem_err_d = 1'b1;
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (md_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (hz.pcSrcE) begin
            // Redirect beats load-use: the PC must load the branch target.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            md_cnt_q   <= 4'd0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_cnt_q   <= md_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Combinational controls are gated so every output reads 0 while reset is held.
    assign hz.stallF    = rst_n & stall_f;
    assign hz.stallD    = rst_n & stall_d;
    assign hz.stallE    = rst_n & stall_e;
    assign hz.stallM    = rst_n & stall_m;
    assign hz.flushD    = rst_n & flush_d;
    assign hz.flushE    = rst_n & flush_e;
    assign hz.flushM    = rst_n & flush_m;
    assign hz.forwardAE = rst_n ? fwd_a : 2'b00;
    assign hz.forwardBE = rst_n ? fwd_b : 2'b00;
    assign hz.mdBusy    = rst_n & (state_q == MD_BUSY);
    assign hz.memErr    = rst_n & mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LATENCY=4, MEM_TIMEOUT=8) with a scoreboard queue
// of expected output vectors compared mid-cycle.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;

    hazard_ctrl_if hz_if ();

    hazard_ctrl #(
        .MD_LATENCY (4),
        .MEM_TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stallF,stallD,stallE,stallM, flushD,flushE,flushM, forwardAE, forwardBE, mdBusy, memErr}
    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [12:0] obs;
    assign obs = {hz_if.stallF, hz_if.stallD, hz_if.stallE, hz_if.stallM,
                  hz_if.flushD, hz_if.flushE, hz_if.flushM,
                  hz_if.forwardAE, hz_if.forwardBE, hz_if.mdBusy, hz_if.memErr};

    localparam logic [3:0] ST_NONE = 4'b0000;
    localparam logic [3:0] ST_LW   = 4'b1100;
    localparam logic [3:0] ST_MD   = 4'b1110;
    localparam logic [3:0] ST_ALL  = 4'b1111;
    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_LW   = 3'b010;
    localparam logic [2:0] FL_MD   = 3'b001;
    localparam logic [2:0] FL_BR   = 3'b110;

    function automatic logic [12:0] ev(input logic [3:0] st, input logic [2:0] fl,
                                       input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00,
                                       input logic busy = 1'b0, input logic err = 1'b0);
        return {st, fl, fa, fb, busy, err};
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed=%b expected=<entry>", obs);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (obs === e.v)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.v);
        end
    endtask

    // Inputs are already applied (posedge+1); push expectation, compare at negedge, advance.
    task automatic step(input string tag, input logic [12:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.rs1D      = 5'd0;
        hz_if.rs2D      = 5'd0;
        hz_if.rs1E      = 5'd0;
        hz_if.rs2E      = 5'd0;
        hz_if.rdE       = 5'd0;
        hz_if.rdM       = 5'd0;
        hz_if.rdW       = 5'd0;
        hz_if.memReadE  = 1'b0;
        hz_if.regWriteM = 1'b0;
        hz_if.regWriteW = 1'b0;
        hz_if.pcSrcE    = 1'b0;
        hz_if.mulDivE   = 1'b0;
        hz_if.memReqM   = 1'b0;
        hz_if.memReadyM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed=still_running expected=finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        // Inputs that would raise every control if reset were not masking them.
        hz_if.memReqM   = 1'b1;
        hz_if.regWriteM = 1'b1;
        hz_if.rdM       = 5'd7;
        hz_if.rs1E      = 5'd7;
        hz_if.mulDivE   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step("reset_outputs_low", ev(ST_NONE, FL_NONE));
        clear_inputs();
        rst_n = 1'b1;
        step("idle_after_reset", ev(ST_NONE, FL_NONE));

        // Load-use hazard, one cycle, then the bubble clears it.
        hz_if.memReadE = 1'b1; hz_if.rdE = 5'd5; hz_if.rs1D = 5'd5;
        step("lw_rs1_stall", ev(ST_LW, FL_LW));
        clear_inputs();
        step("lw_one_cycle", ev(ST_NONE, FL_NONE));
        hz_if.memReadE = 1'b1; hz_if.rdE = 5'd0; hz_if.rs1D = 5'd0;
        step("lw_rd0_no_stall", ev(ST_NONE, FL_NONE));
        hz_if.rdE = 5'd9; hz_if.rs1D = 5'd3; hz_if.rs2D = 5'd9;
        step("lw_rs2_stall", ev(ST_LW, FL_LW));
        clear_inputs();

        // Forwarding priority and x0 suppression.
        hz_if.regWriteM = 1'b1; hz_if.regWriteW = 1'b1;
        hz_if.rdM = 5'd7; hz_if.rdW = 5'd7; hz_if.rs1E = 5'd7;
        step("fwd_a_mem_wins", ev(ST_NONE, FL_NONE, 2'b10, 2'b00));
        hz_if.regWriteM = 1'b0; hz_if.rs2E = 5'd7;
        step("fwd_wb_both", ev(ST_NONE, FL_NONE, 2'b01, 2'b01));
        hz_if.regWriteM = 1'b1; hz_if.rdM = 5'd0; hz_if.rs2E = 5'd0; hz_if.rdW = 5'd4;
        step("fwd_b_x0_none", ev(ST_NONE, FL_NONE, 2'b00, 2'b00));
        hz_if.rdM = 5'd3; hz_if.rs1E = 5'd3; hz_if.rs2E = 5'd4;
        step("fwd_split", ev(ST_NONE, FL_NONE, 2'b10, 2'b01));
        clear_inputs();

        // Mul/div with MD_LATENCY=4: three stall cycles, busy in cycles 1-3.
        hz_if.mulDivE = 1'b1;
        step("md_c0", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b0));
        step("md_c1", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        step("md_c2", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        step("md_c3_result", ev(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b1));
        hz_if.mulDivE = 1'b0;
        step("md_back_idle", ev(ST_NONE, FL_NONE));

        // Mul/div frozen by a three-cycle dmem wait while mdCnt=1: six stall cycles.
        hz_if.mulDivE = 1'b1;
        step("mdm_c0", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b0));
        step("mdm_c1", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        hz_if.memReqM = 1'b1;
        for (int i = 0; i < 3; i++)
            step("mdm_freeze", ev(ST_ALL, FL_NONE, 2'b00, 2'b00, 1'b1));
        hz_if.memReqM = 1'b0;
        step("mdm_last_stall", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        step("mdm_result", ev(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b1));
        hz_if.mulDivE = 1'b0;
        step("mdm_idle", ev(ST_NONE, FL_NONE));

        // Branch over load-use, then memory stall over branch.
        hz_if.memReadE = 1'b1; hz_if.rdE = 5'd5; hz_if.rs1D = 5'd5; hz_if.pcSrcE = 1'b1;
        step("br_over_lw", ev(ST_NONE, FL_BR));
        hz_if.memReqM = 1'b1;
        step("mem_over_br", ev(ST_ALL, FL_NONE));
        hz_if.memReadyM = 1'b1;
        step("ready_no_memstall", ev(ST_NONE, FL_BR));
        clear_inputs();
        step("quiet", ev(ST_NONE, FL_NONE));

        // Watchdog: a 7-cycle wait does not trip it; a broken run restarts the count.
        hz_if.memReqM = 1'b1;
        for (int i = 0; i < 7; i++) step("wd_pre7", ev(ST_ALL, FL_NONE));
        hz_if.memReqM = 1'b0;
        step("wd_break", ev(ST_NONE, FL_NONE));
        hz_if.memReqM = 1'b1;
        for (int i = 0; i < 8; i++) step("wd_run8_no_err", ev(ST_ALL, FL_NONE));
        step("wd_err_frozen", ev(ST_ALL, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b1));
        hz_if.memReadyM = 1'b1;
        step("wd_err_sticky_ready", ev(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b1));
        clear_inputs();
        step("wd_err_sticky_idle", ev(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b0, 1'b1));
        rst_n = 1'b0;
        step("wd_reset_clears", ev(ST_NONE, FL_NONE));
        rst_n = 1'b1;
        step("wd_after_reset", ev(ST_NONE, FL_NONE));

        // Reset in the middle of a mul/div: count restarts after release.
        hz_if.mulDivE = 1'b1;
        step("mdr_c0", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b0));
        step("mdr_c1", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        rst_n = 1'b0;
        step("mdr_in_reset", ev(ST_NONE, FL_NONE));
        rst_n = 1'b1;
        step("mdr_restart_c0", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b0));
        step("mdr_restart_c1", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        step("mdr_restart_c2", ev(ST_MD, FL_MD, 2'b00, 2'b00, 1'b1));
        step("mdr_restart_c3", ev(ST_NONE, FL_NONE, 2'b00, 2'b00, 1'b1));
        hz_if.mulDivE = 1'b0;
        step("mdr_idle", ev(ST_NONE, FL_NONE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
